// File: rtl/system_bus_responder_pkg.sv
// Shared bus definitions: operation and snoop-result encodings, responder FSM states.
package system_bus_responder_pkg;

    localparam int unsigned DEFAULT_ADDR_BITS = 32;

    typedef enum logic [1:0] {
        OpRead       = 2'd0,
        OpWrite      = 2'd1,
        OpInvalidate = 2'd2,
        OpRwim       = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        RsltHit   = 2'd0,
        RsltHitm  = 2'd1,
        RsltNohit = 2'd2
    } snp_rslt_t;

    typedef enum logic [2:0] {
        StIdle,
        StSnoop,
        StCollect,
        StMem,
        StResp
    } state_t;

    // Raw peer encoding to result; the unused code 3 behaves as a miss.
    function automatic snp_rslt_t decode_rslt(input logic [1:0] raw);
        case (raw)
            2'd0:    return RsltHit;
            2'd1:    return RsltHitm;
            default: return RsltNohit;
        endcase
    endfunction

endpackage

// File: rtl/system_bus_responder_if.sv
// Request, snoop, memory and response signals between the responder and its environment.
interface system_bus_responder_if #(
    parameter int unsigned ADDR_BITS = system_bus_responder_pkg::DEFAULT_ADDR_BITS,
    parameter int unsigned NUM_PEERS = 3
);
    import system_bus_responder_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    bus_op_t                req_op;
    logic [ADDR_BITS-1:0]   req_addr;

    logic                   snp_valid;
    bus_op_t                snp_op;
    logic [ADDR_BITS-1:0]   snp_addr;
    logic [NUM_PEERS-1:0]   snp_rslt_valid;
    logic [2*NUM_PEERS-1:0] snp_rslt;

    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic                   mem_ack;

    logic                   rsp_valid;
    snp_rslt_t              rsp_snoop;
    logic                   timeout_err;
    logic [15:0]            hitm_count;

    modport slave (
        input  req_valid, req_op, req_addr, snp_rslt_valid, snp_rslt, mem_ack,
        output req_ready, snp_valid, snp_op, snp_addr, mem_req, mem_we, mem_addr,
        output rsp_valid, rsp_snoop, timeout_err, hitm_count
    );

    modport master (
        output req_valid, req_op, req_addr, snp_rslt_valid, snp_rslt, mem_ack,
        input  req_ready, snp_valid, snp_op, snp_addr, mem_req, mem_we, mem_addr,
        input  rsp_valid, rsp_snoop, timeout_err, hitm_count
    );

endinterface

// File: rtl/system_bus_responder_merge.sv
// Priority merge of per-peer snoop results: HITM over HIT over NOHIT.
module snoop_result_merge
    import system_bus_responder_pkg::*;
#(
    parameter int unsigned NUM_PEERS = 3
) (
    input  logic [2*NUM_PEERS-1:0] rslt,
    output snp_rslt_t              agg
);

    // Scan all peers and pick the strongest result seen.
    always_comb begin
        logic any_hit;
        logic any_hitm;
        any_hit  = 1'b0;
        any_hitm = 1'b0;
        for (int k = 0; k < int'(NUM_PEERS); k++) begin
            case (decode_rslt(rslt[2*k +: 2]))
                RsltHit:  any_hit  = 1'b1;
                RsltHitm: any_hitm = 1'b1;
                default:  ;
            endcase
        end
        if (any_hitm) begin
            agg = RsltHitm;
        end else if (any_hit) begin
            agg = RsltHit;
        end else begin
            agg = RsltNohit;
        end
    end

endmodule

// File: rtl/system_bus_responder.sv
// System bus responder: broadcasts a snoop, collects peer results, optionally accesses
// memory, then reports the aggregated snoop result back to the LLC.
module system_bus_responder
    import system_bus_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int unsigned NUM_PEERS     = 3,
    parameter int unsigned SNOOP_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    system_bus_responder_if.slave bus
);

    localparam int unsigned TimerW = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

    state_t                 state_q, state_d;
    bus_op_t                op_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [NUM_PEERS-1:0]   mask_q;
    logic [2*NUM_PEERS-1:0] rslt_q;
    logic [TimerW-1:0]      timer_q;
    snp_rslt_t              agg_q;
    logic                   timeout_q;
    logic [15:0]            hitm_q;

    logic [NUM_PEERS-1:0]   new_valid;
    logic [NUM_PEERS-1:0]   mask_all;
    logic [2*NUM_PEERS-1:0] eff_rslt;
    snp_rslt_t              merged;
    logic                   all_in;
    logic                   expired;
    logic                   collect_done;

    // Effective per-peer results: captured value, a first strobe this cycle, or NOHIT if missing.
    always_comb begin
        new_valid = (state_q == StCollect) ? bus.snp_rslt_valid : '0;
        mask_all  = mask_q | new_valid;
        eff_rslt  = '0;
        for (int k = 0; k < int'(NUM_PEERS); k++) begin
            if (mask_q[k]) begin
                eff_rslt[2*k +: 2] = rslt_q[2*k +: 2];
            end else if (new_valid[k]) begin
                eff_rslt[2*k +: 2] = bus.snp_rslt[2*k +: 2];
            end else begin
                eff_rslt[2*k +: 2] = RsltNohit;
            end
        end
        all_in       = &mask_all;
        expired      = (timer_q == TimerW'(SNOOP_TIMEOUT - 1));
        collect_done = (state_q == StCollect) && (all_in || expired);
    end

    snoop_result_merge #(
        .NUM_PEERS (NUM_PEERS)
    ) u_merge (
        .rslt (eff_rslt),
        .agg  (merged)
    );

    // Next-state logic; a HITM owner supplies read data, so memory is skipped then.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.req_valid) state_d = StSnoop;
            StSnoop:   state_d = StCollect;
            StCollect: begin
                if (collect_done) begin
                    if (op_q == OpWrite) begin
                        state_d = StMem;
                    end else if (op_q == OpInvalidate || merged == RsltHitm) begin
                        state_d = StResp;
                    end else begin
                        state_d = StMem;
                    end
                end
            end
            StMem:     if (bus.mem_ack) state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State, request latch, snoop capture, timer and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpRead;
            addr_q    <= '0;
            mask_q    <= '0;
            rslt_q    <= '0;
            timer_q   <= '0;
            agg_q     <= snp_rslt_t'('0);
            timeout_q <= 1'b0;
            hitm_q    <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= 1'b0;
            if (state_q == StIdle && bus.req_valid) begin
                op_q   <= bus.req_op;
                addr_q <= bus.req_addr;
            end
            if (state_q == StSnoop) begin
                mask_q  <= '0;
                timer_q <= '0;
            end
            if (state_q == StCollect) begin
                mask_q <= mask_all;
                rslt_q <= eff_rslt;
                if (collect_done) begin
                    agg_q     <= merged;
                    timeout_q <= !all_in;
                    if (merged == RsltHitm) hitm_q <= hitm_q + 16'd1;
                end else begin
                    timer_q <= timer_q + TimerW'(1);
                end
            end
        end
    end

    // Output decode; every output is zero outside its asserting state.
    always_comb begin
        bus.req_ready   = (state_q == StIdle);
        bus.snp_valid   = (state_q == StSnoop);
        bus.snp_op      = (state_q == StSnoop) ? op_q : bus_op_t'('0);
        bus.snp_addr    = (state_q == StSnoop) ? addr_q : '0;
        bus.mem_req     = (state_q == StMem);
        bus.mem_we      = (state_q == StMem) && (op_q == OpWrite);
        bus.mem_addr    = (state_q == StMem) ? addr_q : '0;
        bus.rsp_valid   = (state_q == StResp);
        bus.rsp_snoop   = (state_q == StResp) ? agg_q : snp_rslt_t'('0);
        bus.timeout_err = timeout_q;
        bus.hitm_count  = hitm_q;
    end

endmodule

// File: tb/tb_system_bus_responder.sv
// Directed bench for system_bus_responder: table of transactions plus a reset-in-MEM sequence.
module tb_system_bus_responder;
    import system_bus_responder_pkg::*;

    localparam int unsigned AB    = 32;
    localparam int unsigned NP    = 3;
    localparam int unsigned TO    = 16;
    localparam int          NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    system_bus_responder_if #(.ADDR_BITS(AB), .NUM_PEERS(NP)) bus ();

    system_bus_responder #(
        .ADDR_BITS     (AB),
        .NUM_PEERS     (NP),
        .SNOOP_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bus_op_t     op;
        logic [31:0] addr;
        logic [1:0]  r0, r1, r2;
        int          d0, d1, d2;    // COLLECT cycle of each peer strobe (NEVER = silent)
        int          dup_d;         // second strobe from peer 0
        logic [1:0]  dup_r;
        int          ack;           // MEM cycles before mem_ack
        bit          noise;         // mem_ack held high outside MEM
        logic [1:0]  e_snoop;
        int          e_lat;         // cycles from accept to rsp_valid
        int          e_mem;         // mem_req cycles
        bit          e_we;
        int          e_to;          // timeout_err pulses
    } vec_t;

    int checks = 0;
    int errors = 0;
    int hitm_model = 0;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bus_op_t op, logic [31:0] addr,
                                logic [1:0] r0, int d0, logic [1:0] r1, int d1,
                                logic [1:0] r2, int d2, int dup_d, logic [1:0] dup_r,
                                int ack, bit noise, logic [1:0] es, int el, int em,
                                bit ew, int eto);
        vec_t v;
        v.op = op; v.addr = addr;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.dup_d = dup_d; v.dup_r = dup_r; v.ack = ack; v.noise = noise;
        v.e_snoop = es; v.e_lat = el; v.e_mem = em; v.e_we = ew; v.e_to = eto;
        return v;
    endfunction

    task automatic drive_idle();
        bus.req_valid      = 1'b0;
        bus.req_op         = OpRead;
        bus.req_addr       = '0;
        bus.snp_rslt_valid = '0;
        bus.snp_rslt       = '0;
        bus.mem_ack        = 1'b0;
    endtask

    // Caller must be at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        int rsp_n = -1;
        int rsp_cnt = 0;
        int mem_cyc = 0;
        int to_cnt = 0;
        int snp_cnt = 0;
        int bad_idle = 0;
        int bad_mem = 0;
        logic [1:0] rsp_s = 2'd0;
        int dl [3];
        logic [1:0] rl [3];
        string tag;
        bit hit;
        tag = $sformatf("v%0d", idx);
        dl[0] = v.d0; dl[1] = v.d1; dl[2] = v.d2;
        rl[0] = v.r0; rl[1] = v.r1; rl[2] = v.r2;
        for (int n = 0; n <= v.e_lat + 2; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 0) chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
            if (bus.snp_valid) begin
                snp_cnt++;
                if (n == 1) begin
                    chk({tag, ".snp_op"}, 32'(bus.snp_op), 32'(v.op));
                    chk({tag, ".snp_addr"}, bus.snp_addr, v.addr);
                end
            end else if (bus.snp_op != 0 || bus.snp_addr != 0) begin
                bad_idle++;
            end
            if (bus.mem_req) begin
                mem_cyc++;
                if (bus.mem_we !== v.e_we || bus.mem_addr !== v.addr) bad_mem++;
            end else if (bus.mem_we || bus.mem_addr != 0) begin
                bad_idle++;
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_n < 0) begin
                    rsp_n = n;
                    rsp_s = bus.rsp_snoop;
                end
            end else if (bus.rsp_snoop != 0) begin
                bad_idle++;
            end
            if (bus.timeout_err) to_cnt++;
            // Inputs for this cycle; request fields are scrambled once not offered.
            bus.req_valid = (n == 0);
            bus.req_op    = (n == 0) ? v.op : bus_op_t'(~v.op);
            bus.req_addr  = (n == 0) ? v.addr : ~v.addr;
            for (int k = 0; k < 3; k++) begin
                hit = (n == 2 + dl[k]);
                bus.snp_rslt_valid[k] = hit;
                bus.snp_rslt[2*k +: 2] = hit ? rl[k] : 2'b01;
            end
            if (n == 2 + v.dup_d) begin
                bus.snp_rslt_valid[0] = 1'b1;
                bus.snp_rslt[1:0]     = v.dup_r;
            end
            if (bus.mem_req) bus.mem_ack = (mem_cyc == v.ack + 1);
            else             bus.mem_ack = v.noise;
        end
        drive_idle();
        @(negedge clk);
        chk({tag, ".snp_cnt"}, 32'(snp_cnt), 32'd1);
        chk({tag, ".rsp_cnt"}, 32'(rsp_cnt), 32'd1);
        chk({tag, ".rsp_lat"}, 32'(rsp_n), 32'(v.e_lat));
        chk({tag, ".rsp_snoop"}, 32'(rsp_s), 32'(v.e_snoop));
        chk({tag, ".mem_cycles"}, 32'(mem_cyc), 32'(v.e_mem));
        chk({tag, ".mem_fields"}, 32'(bad_mem), 32'd0);
        chk({tag, ".idle_outputs"}, 32'(bad_idle), 32'd0);
        chk({tag, ".timeout_err"}, 32'(to_cnt), 32'(v.e_to));
        if (v.e_snoop == 2'd1) hitm_model = (hitm_model + 1) & 32'hFFFF;
        chk({tag, ".hitm_count"}, 32'(bus.hitm_count), 32'(hitm_model));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              op            addr          r0 d0     r1 d1     r2 d2      dup      ack nz snoop lat mem we to
        vecs[0]  = mk(OpRead,       32'h0000_1002, 2, 0,     2, 0,     2, 0,      NEVER, 0, 0, 0, 2, 4,  1, 0, 0);
        vecs[1]  = mk(OpRwim,       32'h0000_2001, 0, 0,     1, 1,     2, 2,      NEVER, 0, 0, 0, 1, 5,  0, 0, 0);
        vecs[2]  = mk(OpWrite,      32'h0000_3000, 1, 0,     2, 0,     2, 0,      NEVER, 0, 5, 1, 1, 9,  6, 1, 0);
        vecs[3]  = mk(OpInvalidate, 32'h0000_4000, 0, 0,     0, 3,     0, NEVER,  NEVER, 0, 0, 0, 0, 18, 0, 0, 1);
        vecs[4]  = mk(OpRead,       32'h0000_5000, 0, 1,     2, 0,     3, 2,      NEVER, 0, 0, 0, 0, 6,  1, 0, 0);
        vecs[5]  = mk(OpRead,       32'h0000_6000, 2, 0,     1, 0,     2, 0,      NEVER, 0, 0, 0, 1, 3,  0, 0, 0);
        vecs[6]  = mk(OpRwim,       32'h0000_7000, 2, 0,     2, 0,     2, 0,      NEVER, 0, 2, 1, 2, 6,  3, 0, 0);
        vecs[7]  = mk(OpInvalidate, 32'h0000_8000, 3, 0,     3, 0,     3, 0,      NEVER, 0, 0, 0, 2, 3,  0, 0, 0);
        vecs[8]  = mk(OpRead,       32'h0000_9000, 0, NEVER, 0, NEVER, 0, NEVER,  NEVER, 0, 0, 0, 2, 19, 1, 0, 1);
        vecs[9]  = mk(OpInvalidate, 32'h0000_A000, 2, 0,     2, 0,     1, 15,     NEVER, 0, 0, 0, 1, 18, 0, 0, 0);
        vecs[10] = mk(OpRead,       32'h0000_B000, 0, 0,     2, 2,     2, 2,      1,     1, 0, 0, 0, 6,  1, 0, 0);
        vecs[11] = mk(OpWrite,      32'hFFFF_FFFC, 0, 0,     0, 0,     0, 0,      NEVER, 0, 0, 0, 0, 4,  1, 1, 0);

        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset.snp_valid", 32'(bus.snp_valid), 32'd0);
        chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rsp_snoop", 32'(bus.rsp_snoop), 32'd0);
        chk("reset.timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("reset.hitm_count", 32'(bus.hitm_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while in MEM, with a new request and mem_ack present at the same edge.
        bus.req_valid = 1'b1; bus.req_op = OpWrite; bus.req_addr = 32'h0000_C000;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        bus.snp_rslt_valid = '1; bus.snp_rslt = '0;
        @(negedge clk);
        drive_idle();
        chk("rstmem.mem_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = OpRead; bus.req_addr = 32'h0000_D000;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("rstmem.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmem.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstmem.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmem.hitm_count", 32'(bus.hitm_count), 32'd0);
        hitm_model = 0;
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("rstmem.snp_valid", 32'(bus.snp_valid), 32'd1);
        chk("rstmem.snp_addr", bus.snp_addr, 32'h0000_D000);
        chk("rstmem.snp_op", 32'(bus.snp_op), 32'(OpRead));
        drive_idle();
        @(negedge clk);
        bus.snp_rslt_valid = '1; bus.snp_rslt = 6'b10_10_10;
        @(negedge clk);
        drive_idle();
        chk("rstmem.mem_req_new", 32'(bus.mem_req), 32'd1);
        chk("rstmem.mem_we_new", 32'(bus.mem_we), 32'd0);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("rstmem.rsp_valid_new", 32'(bus.rsp_valid), 32'd1);
        chk("rstmem.rsp_snoop_new", 32'(bus.rsp_snoop), 32'(RsltNohit));
        @(negedge clk);
        chk("rstmem.back_idle", 32'(bus.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_bus_responder.md
SYSTEM_BUS_RESPONDER -- requirements
Module: system_bus_responder

Interface
REQ-001 Parameters SHALL be:
- ADDR_BITS, 32, bus address width.
- NUM_PEERS, 3, number of snooping peer caches.
- SNOOP_TIMEOUT, 16, maximum COLLECT cycles before missing peers are forced to NOHIT.
REQ-002 Ports SHALL be as follows. The block has one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  LLC bus operation request.
- req_ready  out  1  responder can accept a request.
- req_op  in  2  bus_op_t: READ=0, WRITE=1, INVALIDATE=2, RWIM=3.
- req_addr  in  ADDR_BITS  request address.
- snp_valid  out  1  one-cycle snoop broadcast to all peers.
- snp_op  out  2  broadcast operation.
- snp_addr  out  ADDR_BITS  broadcast address.
- snp_rslt_valid  in  NUM_PEERS  per-peer result strobe.
- snp_rslt  in  2*NUM_PEERS  per-peer snp_rslt_t (HIT=0, HITM=1, NOHIT=2), peer k at bits [2k+1:2k].
- mem_req  out  1  memory access request, level.
- mem_we  out  1  1 = memory write, 0 = memory read.
- mem_addr  out  ADDR_BITS  memory address.
- mem_ack  in  1  memory completion.
- rsp_valid  out  1  one-cycle completion pulse to the LLC.
- rsp_snoop  out  2  aggregated snoop result (snp_rslt_t).
- timeout_err  out  1  one-cycle pulse when SNOOP_TIMEOUT expires.
- hitm_count  out  16  number of HITM aggregations; wraps.

Function
REQ-003 FSM states SHALL be IDLE, SNOOP, COLLECT, MEM and RESP. req_ready SHALL equal (state==IDLE).
REQ-004 In IDLE, req_valid=1 SHALL latch req_op and req_addr and transition to SNOOP. Requests in any other state are not accepted.
REQ-005 SNOOP SHALL assert snp_valid for exactly one cycle with the latched op and address, clear the captured mask and timer, and transition to COLLECT.
REQ-006 snp_rslt_valid SHALL be sampled only in COLLECT. The first strobe per peer is captured; later strobes from the same peer are ignored.
REQ-007 The aggregate SHALL be HITM if any captured result is HITM, else HIT if any is HIT, else NOHIT. Encoding 3 counts as NOHIT.
REQ-008 COLLECT SHALL exit in the cycle all peers are captured, counting strobes arriving that same cycle.
REQ-009 If the timer reaches SNOOP_TIMEOUT-1 with peers still missing, those peers SHALL count as NOHIT, timeout_err SHALL pulse for one cycle, and COLLECT SHALL exit.
REQ-010 COLLECT exit routing SHALL be:
- WRITE: to MEM with mem_we=1.
- READ or RWIM with aggregate != HITM: to MEM with mem_we=0.
- READ or RWIM with HITM: to RESP, because the owner supplies the data.
- INVALIDATE: to RESP.
REQ-011 In MEM, mem_req SHALL be held high with stable mem_we and mem_addr (= latched address) until sampled mem_ack=1, then transition to RESP. mem_ack is ignored outside MEM.
REQ-012 RESP SHALL pulse rsp_valid with rsp_snoop = aggregate for one cycle and return to IDLE.
REQ-013 hitm_count SHALL increment by 1 on each COLLECT exit whose aggregate is HITM, wrapping 0xFFFF->0x0000.
REQ-014 Minimum latency SHALL be: accept at cycle T, snp_valid at T+1, rsp_valid at T+3 when no MEM access is made, and T+4 when mem_ack arrives in the first MEM cycle.
REQ-015 Outputs outside their asserting states SHALL be 0.

Reset
REQ-016 rst SHALL force IDLE, clear all outputs, rsp_snoop, the mask, the timer and hitm_count, and drop any in-flight operation with no rsp_valid.
REQ-017 Reset SHALL take precedence over every simultaneous event, including req_valid and mem_ack.

Structure
REQ-018 bus_op_t, snp_rslt_t, the FSM state enum and the ADDR_BITS default SHALL live in the shared defines package also used by the LLC.
REQ-019 The priority merge SHALL be a combinational sub-module, snoop_result_merge, parameterized by NUM_PEERS.

Verification
REQ-020 READ 0x0000_1002; all peers NOHIT in first COLLECT cycle; mem_ack on first MEM cycle -> mem_req with mem_we=0; rsp_valid at T+4 with rsp_snoop=NOHIT.
REQ-021 RWIM 0x0000_2001; peers HIT, HITM, NOHIT on different cycles -> no mem_req; rsp_snoop=HITM; hitm_count 0->1.
REQ-022 WRITE 0x0000_3000; mem_ack delayed 5 cycles -> mem_req held 6 cycles, mem_addr=0x0000_3000; rsp_valid once.
REQ-023 INVALIDATE; peer 2 never responds, others HIT -> timeout_err pulses after 16 COLLECT cycles; rsp_snoop=HIT; no mem_req.
REQ-024 rst asserted during MEM with req_valid high -> next cycle IDLE, mem_req=0, no rsp_valid; the request is accepted one cycle after rst falls.
REQ-025 Peer 0 strobes HIT then HITM before the others respond -> HIT is kept and the aggregate excludes the HITM.
